// File: rtl/wallace_pkg.sv
// Shared types and helpers for the Wallace-pool noise generator: FSM states,
// LFSR constants and the bit-reversal used for quad address generation.
package wallace_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_RD0  = 3'd2,
      ST_RD1  = 3'd3,
      ST_CAP  = 3'd4,
      ST_XF   = 3'd5,
      ST_WR0  = 3'd6,
      ST_WR1  = 3'd7
   } state_t;

   localparam logic [15:0] LFSR_TAPS    = 16'hB400;
   localparam logic [15:0] SEED_DEFAULT = 16'hACE1;
   localparam logic [15:0] LFSR_RESET   = 16'h0001;

   // Full 16-bit reversal; callers top-align a K-bit field and keep the low K bits.
   function automatic logic [15:0] bitreverse(input logic [15:0] x);
      logic [15:0] r;
      r = 16'h0000;
      for (int i = 0; i < 16; i++) begin
         r[i] = x[15-i];
      end
      return r;
   endfunction

   function automatic logic [15:0] lfsr_next(input logic [15:0] l);
      return (l >> 1) ^ (l[0] ? LFSR_TAPS : 16'h0000);
   endfunction

endpackage

// File: rtl/dpram.sv
// Simple true dual-port RAM, synchronous read-first on both ports, no reset on
// the storage array.
module dpram #(
   parameter int n = 10,
   parameter int m = 24
) (
   input  logic         clk,
   input  logic         we_a,
   input  logic [n-1:0] addr_a,
   input  logic [m-1:0] din_a,
   output logic [m-1:0] dout_a,
   input  logic         we_b,
   input  logic [n-1:0] addr_b,
   input  logic [m-1:0] din_b,
   output logic [m-1:0] dout_b
);

   localparam int DEPTH = 1 << n;

   logic [m-1:0] mem [DEPTH];

   // Both ports share one process so the array has a single driver.
   always_ff @(posedge clk) begin
      if (we_a) begin
         mem[addr_a] <= din_a;
      end
      if (we_b) begin
         mem[addr_b] <= din_b;
      end
      dout_a <= mem[addr_a];
      dout_b <= mem[addr_b];
   end

endmodule

// File: rtl/wallace_xform4.sv
// Orthogonal 4-point Wallace transform; t is supplied pre-registered by the
// parent, mode selects the sign convention of the outputs.
module wallace_xform4 #(
   parameter int W = 24
) (
   input  logic [W-1:0] p,
   input  logic [W-1:0] q,
   input  logic [W-1:0] r,
   input  logic [W-1:0] s,
   input  logic [W-1:0] t,
   input  logic         mode,
   output logic [W-1:0] pn,
   output logic [W-1:0] qn,
   output logic [W-1:0] rn,
   output logic [W-1:0] sn
);

   // Differences wrap modulo 2^W by construction.
   always_comb begin
      pn = {W{1'b0}};
      qn = {W{1'b0}};
      rn = {W{1'b0}};
      sn = {W{1'b0}};
      if (mode) begin
         pn = t - p;
         qn = q - t;
         rn = r - t;
         sn = s - t;
      end else begin
         pn = p - t;
         qn = t - q;
         rn = t - r;
         sn = t - s;
      end
   end

endmodule

// File: rtl/wallace_noise_gen.sv
// Wallace-pool noise generator: streamed pool load, LFSR-addressed quad
// transform written back to the pool, emitted quads queued in an output FIFO.
module wallace_noise_gen
   import wallace_pkg::*;
#(
   parameter int W      = 24,
   parameter int AW     = 10,
   parameter int FIFO_D = 8
) (
   input  logic          CK,
   input  logic          RB,
   input  logic          start,
   input  logic [15:0]   seed,
   input  logic [3:0]    cfg_skip,
   input  logic          init_valid,
   input  logic [W-1:0]  init_data,
   output logic          init_ready,
   output logic          out_valid,
   output logic [W-1:0]  out_data,
   input  logic          out_ready,
   output logic          busy
);

   localparam int K  = AW - 2;
   localparam int SW = W + 2;
   localparam int PW = $clog2(FIFO_D);
   localparam int CW = PW + 1;

   state_t          state_r;
   logic [15:0]     lfsr_r;
   logic            mode_r;
   logic [3:0]      skip_cnt_r;
   logic [3:0]      skip_cfg_r;
   logic [AW-1:0]   load_cnt_r;
   logic            init_ready_r;
   logic            busy_r;
   logic [W-1:0]    p_r, q_r, r_r, s_r, t_r;

   logic [K-1:0]    i_p_s, i_q_s, i_r_s, i_s_s;
   logic [AW-1:0]   addr_p_s, addr_q_s, addr_r_s, addr_s_s;
   logic [SW-1:0]   sum_s, half_s;
   logic [W-1:0]    t_s;
   logic [W-1:0]    pn_s, qn_s, rn_s, sn_s;

   logic            we_a_s, we_b_s;
   logic [AW-1:0]   addr_a_s, addr_b_s;
   logic [W-1:0]    din_a_s, din_b_s, dout_a_s, dout_b_s;

   logic [W-1:0]    fifo_mem [FIFO_D];
   logic [PW-1:0]   wr_ptr_r, rd_ptr_r;
   logic [CW-1:0]   cnt_r, cnt_nxt_s;
   logic            out_valid_r;
   logic            emit_s, go_s, push_s, pop_s;
   logic [W-1:0]    push_data_s [4];

   // Quad addresses: one index per pool quarter, so the four never collide.
   always_comb begin
      i_p_s    = lfsr_r[K-1:0];
      i_r_s    = lfsr_r[15:16-K];
      i_q_s    = K'(bitreverse(16'(i_p_s) << (16 - K)));
      i_s_s    = K'(bitreverse(lfsr_r));
      addr_p_s = {2'b00, i_p_s};
      addr_q_s = {2'b01, i_q_s};
      addr_r_s = {2'b10, i_r_s};
      addr_s_s = {2'b11, i_s_s};
   end

   // Half-sum rounded toward zero: add 1 to negative sums before dropping bit 0.
   always_comb begin
      sum_s  = {{2{p_r[W-1]}}, p_r} + {{2{q_r[W-1]}}, q_r}
             + {{2{r_r[W-1]}}, r_r} + {{2{s_r[W-1]}}, s_r};
      half_s = sum_s + {{(SW-1){1'b0}}, sum_s[SW-1]};
      t_s    = half_s[W:1];
   end

   wallace_xform4 #(.W(W)) u_xform (
      .p    (p_r),
      .q    (q_r),
      .r    (r_r),
      .s    (s_r),
      .t    (t_r),
      .mode (mode_r),
      .pn   (pn_s),
      .qn   (qn_s),
      .rn   (rn_s),
      .sn   (sn_s)
   );

   // Pool port steering by FSM state; start suppresses any write that cycle.
   always_comb begin
      we_a_s   = 1'b0;
      we_b_s   = 1'b0;
      addr_a_s = {AW{1'b0}};
      addr_b_s = {AW{1'b0}};
      din_a_s  = {W{1'b0}};
      din_b_s  = {W{1'b0}};
      case (state_r)
         ST_LOAD: begin
            we_a_s   = init_valid && init_ready_r && !start;
            addr_a_s = load_cnt_r;
            din_a_s  = init_data;
         end
         ST_RD0: begin
            addr_a_s = addr_p_s;
            addr_b_s = addr_q_s;
         end
         ST_RD1: begin
            addr_a_s = addr_r_s;
            addr_b_s = addr_s_s;
         end
         ST_WR0: begin
            we_a_s   = !start;
            we_b_s   = !start;
            addr_a_s = addr_p_s;
            addr_b_s = addr_q_s;
            din_a_s  = pn_s;
            din_b_s  = qn_s;
         end
         ST_WR1: begin
            we_a_s   = !start;
            we_b_s   = !start;
            addr_a_s = addr_r_s;
            addr_b_s = addr_s_s;
            din_a_s  = rn_s;
            din_b_s  = sn_s;
         end
         default: begin
            we_a_s = 1'b0;
            we_b_s = 1'b0;
         end
      endcase
   end

   dpram #(.n(AW), .m(W)) u_pool (
      .clk    (CK),
      .we_a   (we_a_s),
      .addr_a (addr_a_s),
      .din_a  (din_a_s),
      .dout_a (dout_a_s),
      .we_b   (we_b_s),
      .addr_b (addr_b_s),
      .din_b  (din_b_s),
      .dout_b (dout_b_s)
   );

   // Free-space test uses the pre-pop count; skipped quads never wait.
   always_comb begin
      emit_s         = (skip_cnt_r == 4'd0);
      go_s           = !emit_s || ((CW'(FIFO_D) - cnt_r) >= CW'(4));
      push_s         = (state_r == ST_WR0) && emit_s && !start;
      pop_s          = out_valid_r && out_ready;
      cnt_nxt_s      = cnt_r + (push_s ? CW'(4) : CW'(0)) - (pop_s ? CW'(1) : CW'(0));
      push_data_s[0] = pn_s;
      push_data_s[1] = qn_s;
      push_data_s[2] = rn_s;
      push_data_s[3] = sn_s;
   end

   // Main controller: load sequencing, six-cycle quad pipeline, LFSR/mode/skip.
   always_ff @(posedge CK or negedge RB) begin
      if (!RB) begin
         state_r      <= ST_IDLE;
         lfsr_r       <= LFSR_RESET;
         mode_r       <= 1'b0;
         skip_cnt_r   <= 4'd0;
         skip_cfg_r   <= 4'd0;
         load_cnt_r   <= {AW{1'b0}};
         init_ready_r <= 1'b0;
         busy_r       <= 1'b0;
         p_r          <= {W{1'b0}};
         q_r          <= {W{1'b0}};
         r_r          <= {W{1'b0}};
         s_r          <= {W{1'b0}};
         t_r          <= {W{1'b0}};
      end else if (start) begin
         state_r      <= ST_LOAD;
         lfsr_r       <= (seed == 16'h0000) ? SEED_DEFAULT : seed;
         mode_r       <= 1'b0;
         skip_cnt_r   <= 4'd0;
         skip_cfg_r   <= cfg_skip;
         load_cnt_r   <= {AW{1'b0}};
         init_ready_r <= 1'b1;
         busy_r       <= 1'b1;
      end else begin
         case (state_r)
            ST_IDLE: begin
               state_r <= ST_IDLE;
            end
            ST_LOAD: begin
               if (init_valid && init_ready_r) begin
                  load_cnt_r <= load_cnt_r + AW'(1);
                  if (load_cnt_r == {AW{1'b1}}) begin
                     state_r      <= ST_RD0;
                     init_ready_r <= 1'b0;
                  end
               end
            end
            ST_RD0: begin
               if (go_s) begin
                  state_r <= ST_RD1;
               end
            end
            ST_RD1: begin
               p_r     <= dout_a_s;
               q_r     <= dout_b_s;
               state_r <= ST_CAP;
            end
            ST_CAP: begin
               r_r     <= dout_a_s;
               s_r     <= dout_b_s;
               state_r <= ST_XF;
            end
            ST_XF: begin
               t_r     <= t_s;
               state_r <= ST_WR0;
            end
            ST_WR0: begin
               state_r <= ST_WR1;
            end
            ST_WR1: begin
               lfsr_r     <= lfsr_next(lfsr_r);
               mode_r     <= ~mode_r;
               skip_cnt_r <= (skip_cnt_r == skip_cfg_r) ? 4'd0 : skip_cnt_r + 4'd1;
               state_r    <= ST_RD0;
            end
            default: begin
               state_r      <= ST_IDLE;
               init_ready_r <= 1'b0;
               busy_r       <= 1'b0;
            end
         endcase
      end
   end

   // FIFO pointers and occupancy; start flushes.
   always_ff @(posedge CK or negedge RB) begin
      if (!RB) begin
         wr_ptr_r    <= {PW{1'b0}};
         rd_ptr_r    <= {PW{1'b0}};
         cnt_r       <= {CW{1'b0}};
         out_valid_r <= 1'b0;
      end else if (start) begin
         wr_ptr_r    <= {PW{1'b0}};
         rd_ptr_r    <= {PW{1'b0}};
         cnt_r       <= {CW{1'b0}};
         out_valid_r <= 1'b0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PW'(4);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PW'(1);
         end
         cnt_r       <= cnt_nxt_s;
         out_valid_r <= (cnt_nxt_s != {CW{1'b0}});
      end
   end

   // FIFO storage: a whole quad lands in four consecutive slots at once.
   always_ff @(posedge CK) begin
      if (push_s) begin
         for (int k = 0; k < 4; k++) begin
            fifo_mem[wr_ptr_r + PW'(k)] <= push_data_s[k];
         end
      end
   end

   assign init_ready = init_ready_r;
   assign busy       = busy_r;
   assign out_valid  = out_valid_r;
   assign out_data   = out_valid_r ? fifo_mem[rd_ptr_r] : {W{1'b0}};

endmodule
